// File: rtl/servo_pkg.sv
// Shared types and defaults for the servo motion sequencers.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int          POS_W       = 8;
  localparam logic [15:0] DIVCLK_DEF  = 16'd1953;
  localparam logic [7:0]  PWM_MIN_DEF = 8'h01;
  localparam logic [7:0]  PWM_MAX_DEF = 8'h20;
  localparam logic [7:0]  PARK_DEF    = 8'h10;

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v,
                                                 input logic [POS_W-1:0] lo,
                                                 input logic [POS_W-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// PWM frame timer: prescaler 0..DIVCLK feeding an 8b frame counter;
// frame_tick marks the prescaler wrap that rolls the frame counter over.
module servo_frame_timer #(
  parameter logic [15:0] DIVCLK = 16'd1953
) (
  input  logic clk,
  input  logic resetb,
  output logic frame_tick
);

  logic [15:0] presc;
  logic [7:0]  frame_cnt;
  logic        wrap;

  assign wrap       = (presc == DIVCLK);
  assign frame_tick = wrap && (frame_cnt == 8'hFF);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      presc     <= '0;
      frame_cnt <= '0;
    end else if (wrap) begin
      presc     <= '0;
      frame_cnt <= frame_cnt + 8'd1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Servo motion sequencer: takes position commands, slews set_pwm toward the
// target by a bounded step once per PWM frame, then holds for N frames.
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter logic [15:0] DIVCLK  = DIVCLK_DEF,
  parameter logic [7:0]  PWM_MIN = PWM_MIN_DEF,
  parameter logic [7:0]  PWM_MAX = PWM_MAX_DEF,
  parameter logic [7:0]  PARK    = PARK_DEF
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [POS_W-1:0] cmd_target,
  input  logic [3:0]       cmd_step,
  input  logic [7:0]       cmd_hold,
  input  logic             abort,
  output logic [POS_W-1:0] set_pwm,
  output logic [15:0]      div_clk,
  output logic             frame_tick,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output state_e           state
);

  // Command handshake: a command transfers on the rising edge where
  // cmd_valid && cmd_ready; cmd_ready is high only in IDLE and cmd_valid is
  // ignored otherwise, so the requester must hold its fields until that edge.

  logic [POS_W-1:0] tgt;
  logic [3:0]       step;
  logic [7:0]       hold;
  logic [7:0]       hold_cnt;
  logic [POS_W:0]   diff;
  logic [POS_W:0]   mag;
  logic             near;
  logic             reach;
  logic [POS_W-1:0] step_pwm;

  assign div_clk = DIVCLK;

  servo_frame_timer #(.DIVCLK(DIVCLK)) u_timer (
    .clk        (clk),
    .resetb     (resetb),
    .frame_tick (frame_tick)
  );

  // 9b two's-complement difference; bit 8 is the sign, so no wraparound.
  assign diff     = {1'b0, tgt} - {1'b0, set_pwm};
  assign mag      = diff[POS_W] ? (~diff + 9'd1) : diff;
  assign near     = (mag <= {5'd0, step});
  assign reach    = (set_pwm == tgt) || (frame_tick && near);
  assign step_pwm = diff[POS_W] ? (set_pwm - {4'd0, step}) : (set_pwm + {4'd0, step});

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state     <= IDLE;
      set_pwm   <= PARK;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      tgt       <= PARK;
      step      <= 4'd1;
      hold      <= '0;
      hold_cnt  <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            tgt       <= clamp_pos(cmd_target, PWM_MIN, PWM_MAX);
            step      <= (cmd_step == 4'd0) ? 4'd1 : cmd_step;
            hold      <= cmd_hold;
            state     <= RAMP;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RAMP: begin
          if (abort) begin
            aborted   <= 1'b1;
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (reach) begin
            set_pwm <= tgt;
            if (hold == 8'd0) begin
              done      <= 1'b1;
              state     <= IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              hold_cnt <= hold;
              state    <= HOLD;
            end
          end else if (frame_tick) begin
            set_pwm <= step_pwm;
          end
        end
        HOLD: begin
          if (abort) begin
            aborted   <= 1'b1;
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (frame_tick) begin
            if (hold_cnt == 8'd1) begin
              done      <= 1'b1;
              state     <= IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
